seg7_pattern_monitor: RTL and testbench

Receive-side companion to the 4-bit counter / 7-segment encoder path. It samples a 7-segment drive bus and applies a stability filter. It decodes each stable pattern back to a hex nibble and checks that successive accepted values step by +1 mod 16, counting every anomaly. It sits between the `seg` outputs of a display-driving design and the bench or debug logic, closing the loop on counter-to-display paths.

---
 rtl/seg7_pattern_monitor.sv | 201 ++++++++++++++++++++
 tb/tb_seg7_pattern_monitor.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_pattern_monitor.sv
// seg7_pattern_monitor: filters a 7-segment bus, decodes stable
// patterns to hex and flags breaks in the +1 mod 16 sequence.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   seg_in     raw segment bus {g,f,e,d,c,b,a}
//   clear_err  synchronous clear of err_count
//   value      last accepted hex digit
//   valid      last accepted pattern was a digit
//   invalid    last accepted pattern was neither digit nor blank
//   new_value  one-cycle pulse per accepted digit
//   seq_error  one-cycle pulse per out-of-sequence digit
//   err_count  saturating count of sequence errors + invalids
module seg7_pattern_monitor #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  input  logic             clear_err,
  output logic [3:0]       value,
  output logic             valid,
  output logic             invalid,
  output logic             new_value,
  output logic             seq_error,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic {
    S_WAIT,
    S_LOCKED
  } state_e;

  // all segments off, expressed in the bus polarity
  localparam logic [6:0] BLANK_RAW =
    ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] LAST_CNT =
    4'(STABLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [6:0]       cand_q, cand_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             have_prev_q, have_prev_d;
  logic [3:0]       prev_q, prev_d;
  logic [3:0]       value_q, value_d;
  logic             valid_q, valid_d;
  logic             invalid_q, invalid_d;
  logic             new_value_q, new_value_d;
  logic             seq_error_q, seq_error_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic [6:0] lit;
  logic       is_digit;
  logic       is_blank;
  logic [3:0] dig;
  logic       accept;
  logic       seq_bad;
  logic       inc;

  assign lit = ACTIVE_LOW ? ~seg_in : seg_in;
  assign is_blank = (lit == 7'h00);

  always_comb begin
    is_digit = 1'b1;
    dig      = 4'h0;
    case (lit)
      7'h3F: dig = 4'h0;
      7'h06: dig = 4'h1;
      7'h5B: dig = 4'h2;
      7'h4F: dig = 4'h3;
      7'h66: dig = 4'h4;
      7'h6D: dig = 4'h5;
      7'h7D: dig = 4'h6;
      7'h07: dig = 4'h7;
      7'h7F: dig = 4'h8;
      7'h6F: dig = 4'h9;
      7'h77: dig = 4'hA;
      7'h7C: dig = 4'hB;
      7'h39: dig = 4'hC;
      7'h5E: dig = 4'hD;
      7'h79: dig = 4'hE;
      7'h71: dig = 4'hF;
      default: is_digit = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      S_WAIT: begin
        if (seg_in != cand_q) begin
          cand_d = seg_in;
          cnt_d  = 4'd0;
        end else if (cnt_q == LAST_CNT) begin
          accept  = 1'b1;
          state_d = S_LOCKED;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_LOCKED: begin
        if (seg_in != cand_q) begin
          state_d = S_WAIT;
          cand_d  = seg_in;
          cnt_d   = 4'd0;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  // repeating the previous digit is a glitch
  // re-accept, not a sequence break
  assign seq_bad = have_prev_q
                && (dig != prev_q)
                && (dig != prev_q + 4'd1);

  always_comb begin
    value_d     = value_q;
    valid_d     = valid_q;
    invalid_d   = invalid_q;
    new_value_d = 1'b0;
    seq_error_d = 1'b0;
    have_prev_d = have_prev_q;
    prev_d      = prev_q;
    inc         = 1'b0;
    if (accept) begin
      if (is_digit) begin
        value_d     = dig;
        valid_d     = 1'b1;
        invalid_d   = 1'b0;
        new_value_d = 1'b1;
        seq_error_d = seq_bad;
        inc         = seq_bad;
        prev_d      = dig;
        have_prev_d = 1'b1;
      end else if (is_blank) begin
        valid_d     = 1'b0;
        invalid_d   = 1'b0;
        have_prev_d = 1'b0;
      end else begin
        valid_d     = 1'b0;
        invalid_d   = 1'b1;
        inc         = 1'b1;
        have_prev_d = 1'b0;
      end
    end
  end

  // clear wins over a same-edge increment
  always_comb begin
    err_d = err_q;
    if (clear_err) begin
      err_d = '0;
    end else if (inc && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_WAIT;
      cand_q      <= BLANK_RAW;
      cnt_q       <= 4'd0;
      have_prev_q <= 1'b0;
      prev_q      <= 4'd0;
      value_q     <= 4'd0;
      valid_q     <= 1'b0;
      invalid_q   <= 1'b0;
      new_value_q <= 1'b0;
      seq_error_q <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      have_prev_q <= have_prev_d;
      prev_q      <= prev_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      invalid_q   <= invalid_d;
      new_value_q <= new_value_d;
      seq_error_q <= seq_error_d;
      err_q       <= err_d;
    end
  end

  assign value     = value_q;
  assign valid     = valid_q;
  assign invalid   = invalid_q;
  assign new_value = new_value_q;
  assign seq_error = seq_error_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_seg7_pattern_monitor.sv
// tb_seg7_pattern_monitor: directed table, corner
// sequences and random stimulus against a run-length model.
module tb_seg7_pattern_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       clear_err;
  logic [6:0] seg_a;
  logic [6:0] seg_b;

  assign seg_b = ~seg_a;

  logic [3:0] val_a, val_b;
  logic       vld_a, vld_b;
  logic       inv_a, inv_b;
  logic       nv_a, nv_b;
  logic       se_a, se_b;
  logic [7:0] err_a;
  logic [1:0] err_b;

  seg7_pattern_monitor u_a (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_a),
    .clear_err (clear_err),
    .value     (val_a),
    .valid     (vld_a),
    .invalid   (inv_a),
    .new_value (nv_a),
    .seq_error (se_a),
    .err_count (err_a)
  );

  seg7_pattern_monitor #(
    .STABLE_CYCLES (2),
    .ACTIVE_LOW    (1'b0),
    .CNT_W         (2)
  ) u_b (
    .clk       (clk),
    .reset     (reset),
    .seg_in    (seg_b),
    .clear_err (clear_err),
    .value     (val_b),
    .valid     (vld_b),
    .invalid   (inv_b),
    .new_value (nv_b),
    .seq_error (se_b),
    .err_count (err_b)
  );

  int total = 0;
  int bad   = 0;

  logic [6:0] lit_tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  // model: instance 0 = u_a, 1 = u_b
  int         m_stab [2] = '{4, 2};
  int         m_max  [2] = '{255, 3};
  bit         m_al   [2] = '{1'b1, 1'b0};
  logic [6:0] m_last [2];
  int         m_run  [2];
  bit         m_hp   [2];
  int         m_prev [2];
  int         m_val  [2];
  int         m_vld  [2];
  int         m_inv  [2];
  int         m_nv   [2];
  int         m_se   [2];
  int         m_err  [2];

  int na, sa;

  function automatic int find_digit(
    input logic [6:0] lit
  );
    for (int i = 0; i < 16; i++)
      if (lit_tbl[i] == lit) return i;
    return -1;
  endfunction

  // a pattern is accepted once, when its run of
  // identical samples reaches STABLE_CYCLES+1 edges
  function automatic void mstep(
    input int m,
    input logic r,
    input logic c,
    input logic [6:0] raw
  );
    logic [6:0] lit;
    int d;
    bit inc;
    if (r) begin
      m_last[m] = m_al[m] ? 7'h7F : 7'h00;
      m_run[m]  = 1;
      m_hp[m]   = 0;
      m_prev[m] = 0;
      m_val[m]  = 0;
      m_vld[m]  = 0;
      m_inv[m]  = 0;
      m_nv[m]   = 0;
      m_se[m]   = 0;
      m_err[m]  = 0;
      return;
    end
    m_nv[m] = 0;
    m_se[m] = 0;
    inc = 0;
    if (raw == m_last[m]) begin
      if (m_run[m] < 1000) m_run[m]++;
    end else begin
      m_last[m] = raw;
      m_run[m]  = 1;
    end
    if (m_run[m] == m_stab[m] + 1) begin
      lit = m_al[m] ? ~raw : raw;
      d = find_digit(lit);
      if (d >= 0) begin
        if (m_hp[m] && d != m_prev[m]
            && d != (m_prev[m] + 1) % 16) begin
          m_se[m] = 1;
          inc = 1;
        end
        m_val[m]  = d;
        m_vld[m]  = 1;
        m_inv[m]  = 0;
        m_nv[m]   = 1;
        m_prev[m] = d;
        m_hp[m]   = 1;
      end else if (lit == 7'h00) begin
        m_vld[m] = 0;
        m_inv[m] = 0;
        m_hp[m]  = 0;
      end else begin
        m_vld[m] = 0;
        m_inv[m] = 1;
        m_hp[m]  = 0;
        inc = 1;
      end
    end
    if (c) m_err[m] = 0;
    else if (inc && m_err[m] < m_max[m])
      m_err[m]++;
  endfunction

  task automatic chk(
    input string name,
    input int act,
    input int exp
  );
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d",
               name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("a.value", int'(val_a), m_val[0]);
    chk("a.valid", int'(vld_a), m_vld[0]);
    chk("a.invalid", int'(inv_a), m_inv[0]);
    chk("a.new_value", int'(nv_a), m_nv[0]);
    chk("a.seq_error", int'(se_a), m_se[0]);
    chk("a.err_count", int'(err_a), m_err[0]);
    chk("b.value", int'(val_b), m_val[1]);
    chk("b.valid", int'(vld_b), m_vld[1]);
    chk("b.invalid", int'(inv_b), m_inv[1]);
    chk("b.new_value", int'(nv_b), m_nv[1]);
    chk("b.seq_error", int'(se_b), m_se[1]);
    chk("b.err_count", int'(err_b), m_err[1]);
  endtask

  task automatic step(
    input logic [6:0] s,
    input logic c,
    input logic r
  );
    seg_a     = s;
    clear_err = c;
    reset     = r;
    @(posedge clk);
    mstep(0, r, c, s);
    mstep(1, r, c, ~s);
    #1;
    check_all();
    na += int'(nv_a);
    sa += int'(se_a);
  endtask

  typedef struct {
    logic [6:0] seg;
    int hold;
    int val;
    int vld;
    int inv;
    int err;
    int nv;
    int se;
  } vec_t;

  vec_t tbl[$];

  logic [6:0] seq_raw [16] = '{
    7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00,
    7'h10, 7'h08, 7'h03, 7'h46,
    7'h21, 7'h06, 7'h0E, 7'h40
  };

  initial begin
    int nz, first;
    int cur, hold, r;
    logic [6:0] s;
    logic [6:0] lit;

    // full count-up with wrap, then glitch,
    // skip, invalid and recovery
    for (int i = 0; i < 16; i++)
      tbl.push_back('{seq_raw[i], 6, (i + 1) % 16,
                      1, 0, 0, 1, 0});
    tbl.push_back('{7'h79, 6, 1, 1, 0, 0, 1, 0});
    tbl.push_back('{7'h24, 2, 1, 1, 0, 0, 0, 0});
    tbl.push_back('{7'h79, 6, 1, 1, 0, 0, 1, 0});
    tbl.push_back('{7'h30, 6, 3, 1, 0, 1, 1, 1});
    tbl.push_back('{7'h7E, 6, 3, 0, 1, 2, 0, 0});
    tbl.push_back('{7'h24, 6, 2, 1, 0, 2, 1, 0});

    na = 0;
    sa = 0;
    seg_a = 7'h7F;
    clear_err = 1'b0;
    reset = 1'b1;
    step(7'h7F, 1'b0, 1'b1);
    step(7'h7F, 1'b0, 1'b1);
    chk("rst.value", int'(val_a), 0);
    chk("rst.valid", int'(vld_a), 0);
    chk("rst.err", int'(err_a), 0);

    // blank held: nothing visible
    nz = 0;
    for (int i = 0; i < 20; i++) begin
      step(7'h7F, 1'b0, 1'b0);
      if (val_a != 0 || vld_a || inv_a || nv_a
          || se_a || err_a != 0) nz++;
    end
    chk("blank.quiet", nz, 0);

    // first digit lands on the 5th edge
    na = 0;
    sa = 0;
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      step(7'h40, 1'b0, 1'b0);
      if (nv_a && first < 0) first = i;
    end
    chk("first.edge", first, 5);
    chk("first.pulses", na, 1);
    chk("first.value", int'(val_a), 0);
    chk("first.valid", int'(vld_a), 1);
    chk("first.seqerr", sa, 0);

    foreach (tbl[k]) begin
      na = 0;
      sa = 0;
      for (int i = 0; i < tbl[k].hold; i++)
        step(tbl[k].seg, 1'b0, 1'b0);
      chk("tbl.value", int'(val_a), tbl[k].val);
      chk("tbl.valid", int'(vld_a), tbl[k].vld);
      chk("tbl.invalid", int'(inv_a), tbl[k].inv);
      chk("tbl.err", int'(err_a), tbl[k].err);
      chk("tbl.nv", na, tbl[k].nv);
      chk("tbl.se", sa, tbl[k].se);
    end

    // three more errors: A reaches 5, B saturates
    for (int i = 0; i < 6; i++) step(7'h12, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(7'h7E, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(7'h12, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(7'h40, 1'b0, 1'b0);
    chk("sat.a", int'(err_a), 5);
    chk("sat.b", int'(err_b), 3);

    // clear on the same edge as an invalid accept
    for (int i = 0; i < 4; i++) step(7'h7E, 1'b0, 1'b0);
    chk("clr.pre_inv", int'(inv_a), 0);
    step(7'h7E, 1'b1, 1'b0);
    chk("clr.inv", int'(inv_a), 1);
    chk("clr.a", int'(err_a), 0);
    chk("clr.b", int'(err_b), 0);
    step(7'h7E, 1'b0, 1'b0);
    chk("clr.hold", int'(err_a), 0);

    // reset with cnt=2 of a pending window
    for (int i = 0; i < 3; i++) step(7'h79, 1'b0, 1'b0);
    na = 0;
    step(7'h79, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(7'h7F, 1'b0, 1'b0);
    chk("midrst.nv", na, 0);
    chk("midrst.value", int'(val_a), 0);
    chk("midrst.valid", int'(vld_a), 0);
    chk("midrst.inv", int'(inv_a), 0);

    // random patterns against the model
    cur = 0;
    for (int n = 0; n < 2500; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        cur = (cur + 1) % 16;
        lit = lit_tbl[cur];
      end else if (r == 6) begin
        lit = lit_tbl[cur];
      end else if (r == 7) begin
        cur = $urandom_range(0, 15);
        lit = lit_tbl[cur];
      end else if (r == 8) begin
        lit = 7'h00;
      end else begin
        lit = 7'($urandom_range(0, 127));
      end
      s = ~lit;
      hold = $urandom_range(1, 7);
      for (int i = 0; i < hold; i++)
        step(s, $urandom_range(0, 40) == 0,
             $urandom_range(0, 400) == 0);
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
